// File: rtl/smpl_rdout_sched.sv
// Readout scheduler: fetches samples from the sample memory one at a time and
// streams their enabled 8-bit channel groups, lowest group first, to a byte-wide UART.
module smpl_rdout_sched #(
  parameter int SMPL_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [CNT_WIDTH-1:0]    cnt_i,
  input  logic [SMPL_WIDTH/8-1:0] grp_en_i,
  output logic                    read_o,
  input  logic [SMPL_WIDTH-1:0]   d_i,
  input  logic                    tx_rdy_i,
  output logic                    tx_stb_o,
  output logic [7:0]              tx_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int BYTES = SMPL_WIDTH / 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [BYTES-1:0]      mask_q, mask_d;
  logic [BYTES-1:0]      rem_q, rem_d;
  logic [SMPL_WIDTH-1:0] smpl_q, smpl_d;
  logic [7:0]            tx_q, tx_d;
  logic                  done_q, done_d;
  logic [7:0]            sel_byte;
  logic                  tx_stb;
  logic                  rd_req;

  // rem_q holds the groups of the current sample still to be sent; its lowest set bit is next.
  always_comb begin
    sel_byte = 8'h00;
    for (int k = BYTES - 1; k >= 0; k--) begin
      if (rem_q[k]) sel_byte = smpl_q[k*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    rem_d   = rem_q;
    smpl_d  = smpl_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    tx_stb  = (state_q == S_SEND) && tx_rdy_i && !abort_i;
    rd_req  = (state_q == S_FETCH) && !abort_i;

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          if ((cnt_i != '0) && (grp_en_i != '0)) begin
            cnt_d   = cnt_i;
            mask_d  = grp_en_i;
            state_d = S_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        smpl_d  = d_i;
        rem_d   = mask_q;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_stb) begin
          tx_d    = sel_byte;
          rem_d   = rem_q & (rem_q - BYTES'(1));
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rem_q != '0) begin
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the active state decided, including a final done.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      rem_q   <= '0;
      smpl_q  <= '0;
      tx_q    <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      rem_q   <= rem_d;
      smpl_q  <= smpl_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // tx_o shows the new byte during its strobe cycle and holds it until the next strobe.
  assign tx_o     = tx_stb ? sel_byte : tx_q;
  assign tx_stb_o = tx_stb;
  assign read_o   = rd_req;
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = done_q;

endmodule

// File: tb/tb_smpl_rdout_sched.sv
// Randomized bench for smpl_rdout_sched: a memory responder plus a byte scoreboard
// built from the enabled groups of each sample, with directed corner cases.
module tb_smpl_rdout_sched;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [15:0] cnt_i = '0;
  logic [3:0]  grp_en_i = '0;
  logic        read_o;
  logic [31:0] d_i = '0;
  logic        tx_rdy_i = 1'b0;
  logic        tx_stb_o;
  logic [7:0]  tx_o;
  logic        busy_o;
  logic        done_o;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int stb_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_stb_cyc = -1;
  int start_cyc = 0;
  int rd0, stb0, done0;
  logic [31:0] mem_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  last_tx = 8'h00;
  logic        prev_stb = 1'b0;
  logic        rd_flag = 1'b0;

  smpl_rdout_sched #(.SMPL_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .cnt_i(cnt_i), .grp_en_i(grp_en_i), .read_o(read_o), .d_i(d_i),
    .tx_rdy_i(tx_rdy_i), .tx_stb_o(tx_stb_o), .tx_o(tx_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Memory responder and output monitor, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (rst_i) begin
      last_tx  = 8'h00;
      prev_stb = 1'b0;
      rd_flag  = 1'b0;
    end else begin
      if (read_o) begin
        rd_cnt++;
        if (mem_q.size() == 0) begin
          checkOutput("mem_underrun", 32'd1, 32'd0);
          d_i = $urandom;
        end else begin
          d_i = mem_q.pop_front();
        end
        rd_flag = 1'b1;
      end else if (rd_flag) begin
        rd_flag = 1'b0;
      end else begin
        d_i = $urandom;
      end
      if (tx_stb_o) begin
        stb_cnt++;
        if (first_stb_cyc < 0) first_stb_cyc = cyc;
        checkOutput("hold_gap", {31'd0, prev_stb}, 32'd0);
        if (exp_q.size() == 0) checkOutput("extra_stb", 32'd1, 32'd0);
        else checkOutput("tx_byte", {24'd0, tx_o}, {24'd0, exp_q.pop_front()});
        last_tx = tx_o;
      end else begin
        checkOutput("tx_hold", {24'd0, tx_o}, {24'd0, last_tx});
      end
      prev_stb = tx_stb_o;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic loadSample(input logic [31:0] s, input logic [3:0] mask);
    mem_q.push_back(s);
    for (int g = 0; g < 4; g++) begin
      if (mask[g]) exp_q.push_back(s[g*8 +: 8]);
    end
  endtask

  task automatic kickOff(input int n, input logic [3:0] mask, input bit rand_fill);
    if (rand_fill) begin
      for (int i = 0; i < n; i++) loadSample($urandom, mask);
    end
    @(posedge clk_i); #1;
    rd0 = rd_cnt; stb0 = stb_cnt; done0 = done_cnt;
    first_stb_cyc = -1;
    start_cyc = cyc;
    cnt_i = 16'(n); grp_en_i = mask; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    cnt_i = 16'($urandom_range(0, 9)); grp_en_i = 4'($urandom);
  endtask

  // mode 0: ready always high; 1: random ready; 2: 20-cycle stall after the first byte.
  task automatic applyStimulus(input int n, input logic [3:0] mask, input int mode,
                               input bit dbl, input bit rand_fill);
    int k = 0;
    int stall = 0;
    int stb_s = 0;
    int rd_s = 0;
    bit stall_checked = 0;
    if (mode != 1) tx_rdy_i = 1'b1;
    kickOff(n, mask, rand_fill);
    while (done_cnt == done0 && k < 3000) begin
      if (mode == 1) tx_rdy_i = ($urandom_range(0, 99) < 60);
      if (mode == 2) begin
        if (stb_cnt - stb0 >= 1 && stall < 20) begin
          if (stall == 0) begin stb_s = stb_cnt; rd_s = rd_cnt; end
          tx_rdy_i = 1'b0;
          stall++;
        end else begin
          tx_rdy_i = 1'b1;
          if (stall == 20 && !stall_checked) begin
            checkOutput("stall_stb", stb_cnt, stb_s);
            checkOutput("stall_rd", rd_cnt, rd_s);
            stall_checked = 1;
          end
        end
      end
      start_i = (dbl && k == 1);
      if (dbl && k == 1) begin
        cnt_i = 16'd7; grp_en_i = 4'hF;
      end
      @(posedge clk_i); #1;
      start_i = 1'b0;
      k++;
    end
    if (k >= 3000) checkOutput("timeout", 32'd1, 32'd0);
    checkOutput("done_cnt", done_cnt - done0, 32'd1);
    checkOutput("read_cnt", rd_cnt - rd0, n);
    checkOutput("exp_left", exp_q.size(), 32'd0);
    checkOutput("busy_end", {31'd0, busy_o}, 32'd0);
    if (mode == 0) begin
      checkOutput("first_stb", first_stb_cyc - start_cyc, 32'd3);
      checkOutput("done_lat", done_cyc - start_cyc, 1 + n * (2 + 2 * $countones(mask)));
    end
    @(posedge clk_i); #1;
    checkOutput("done_pulse", {31'd0, done_o}, 32'd0);
  endtask

  task automatic emptyStart(input int n, input logic [3:0] mask);
    kickOff(n, mask, 0);
    checkOutput("empty_done", {31'd0, done_o}, 32'd1);
    checkOutput("empty_busy", {31'd0, busy_o}, 32'd0);
    @(posedge clk_i); #1;
    checkOutput("empty_done2", {31'd0, done_o}, 32'd0);
    checkOutput("empty_busy2", {31'd0, busy_o}, 32'd0);
    checkOutput("empty_rd", rd_cnt - rd0, 32'd0);
  endtask

  task automatic waitFirstStrobe();
    int k = 0;
    while (stb_cnt == stb0 && k < 50) begin
      @(posedge clk_i); #1;
      k++;
    end
    if (k >= 50) checkOutput("strobe_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_read", {31'd0, read_o}, 32'd0);
    checkOutput("rst_stb", {31'd0, tx_stb_o}, 32'd0);
    checkOutput("rst_tx", {24'd0, tx_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_done", {31'd0, done_o}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    $display("[TB] directed: two full samples");
    loadSample(32'hDDCCBBAA, 4'hF);
    loadSample(32'h44332211, 4'hF);
    applyStimulus(2, 4'hF, 0, 0, 0);

    $display("[TB] directed: sparse mask");
    loadSample(32'hDDCCBBAA, 4'b0101);
    applyStimulus(1, 4'b0101, 0, 0, 0);

    $display("[TB] directed: transmitter stall");
    applyStimulus(2, 4'hF, 2, 0, 1);

    $display("[TB] directed: empty starts");
    emptyStart(0, 4'hF);
    emptyStart(3, 4'h0);

    $display("[TB] random runs");
    for (int r = 0; r < 12; r++) begin
      applyStimulus($urandom_range(1, 4), 4'($urandom_range(1, 15)), 1, ($urandom_range(0, 1) == 1), 1);
    end

    $display("[TB] directed: abort during send");
    tx_rdy_i = 1'b1;
    kickOff(3, 4'hF, 1);
    waitFirstStrobe();
    tx_rdy_i = 1'b0;
    @(posedge clk_i); #1;
    abort_i = 1'b1;
    checkOutput("abort_busy_before", {31'd0, busy_o}, 32'd1);
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    tx_rdy_i = 1'b1;
    checkOutput("abort_busy", {31'd0, busy_o}, 32'd0);
    repeat (10) @(posedge clk_i);
    #1;
    checkOutput("abort_stb", stb_cnt - stb0, 32'd1);
    checkOutput("abort_done", done_cnt - done0, 32'd0);
    checkOutput("abort_rd", rd_cnt - rd0, 32'd1);
    mem_q.delete();
    exp_q.delete();
    applyStimulus(1, 4'($urandom_range(1, 15)), 0, 0, 1);

    $display("[TB] directed: abort and start together in idle");
    rd0 = rd_cnt; done0 = done_cnt;
    start_i = 1'b1; abort_i = 1'b1; cnt_i = 16'd2; grp_en_i = 4'hF;
    @(posedge clk_i); #1;
    start_i = 1'b0; abort_i = 1'b0;
    checkOutput("abst_busy", {31'd0, busy_o}, 32'd0);
    repeat (4) @(posedge clk_i);
    #1;
    checkOutput("abst_rd", rd_cnt - rd0, 32'd0);
    checkOutput("abst_done", done_cnt - done0, 32'd0);

    $display("[TB] directed: reset in hold");
    tx_rdy_i = 1'b1;
    kickOff(2, 4'hF, 1);
    waitFirstStrobe();
    checkOutput("pre_rst_busy", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    checkOutput("arst_read", {31'd0, read_o}, 32'd0);
    checkOutput("arst_stb", {31'd0, tx_stb_o}, 32'd0);
    checkOutput("arst_tx", {24'd0, tx_o}, 32'd0);
    checkOutput("arst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("arst_done", {31'd0, done_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    mem_q.delete();
    exp_q.delete();
    checkOutput("rst_no_done", done_cnt - done0, 32'd0);
    applyStimulus(1, 4'($urandom_range(1, 15)), 0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
